mc_control: RTL and testbench
=============================

// Module: mc_control
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath (pc, i_mem/d_mem, regfile, ula, ula_ctrl).
//  Moore FSM: each instruction takes FETCH/DECODE/EXEC/MEM/WB steps and the ULA is reused for PC+4 and branch target.
//  Stalls on a memory ready handshake. Traps on illegal opcodes and on memory timeouts.
//  ALUOp feeds the existing ula_ctrl block unchanged.
// PARAMETERS
//  RA_REG      31  register written by jal
//  WAIT_LIMIT  16  max cycles a memory state may wait for mem_ready; 0 disables the timeout
// PORTS
//  clock          in   1  rising-edge clock, single clock domain
//  reset          in   1  asynchronous, active-low reset
//  opcode         in   6  instruction[31:26] from the IR
//  func           in   6  instruction[5:0] from the IR
//  zero           in   1  ULA Zero_flag
//  mem_ready      in   1  memory completes this cycle's access
//  pc_write       out  1  load PC (unconditional, or a qualified branch)
//  i_or_d         out  1  memory address mux: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load IR
//  reg_write      out  1  regfile write enable
//  reg_dst        out  2  write-address mux: 00=rt, 01=rd, 10=RA_REG
//  mem_to_reg     out  2  write-data mux: 00=ALUOut, 01=MDR, 10=PC
//  alu_src_a      out  1  ULA A mux: 0=PC, 1=rs
//  alu_src_b      out  2  ULA B mux: 00=rt, 01=4, 10=SignExtImm, 11=SignExtImm<<2
//  alu_op         out  2  to ula_ctrl: 00=add, 01=sub, 10=use func
//  pc_source      out  2  PC mux: 00=ULA result, 01=ALUOut, 10=jump address, 11=rs (jr)
//  retired        out  1  one-cycle pulse in the final state of each instruction
//  halted         out  1  FSM is in the ERROR state
//  err_code       out  2  00=none, 01=illegal opcode/func, 10=memory timeout
// BEHAVIOUR
//  Reset
//   - reset=0 forces state=FETCH, wait_cnt=0, err_code=00.
//   - All outputs are 0 while reset=0, including mem_read. Outputs are combinational from state and are gated by reset.
//   - Reset asserted in any state, including mid-wait, aborts immediately. No memory write may be issued afterwards.
//  Unlisted outputs are 0 in every state.
//  FETCH
//   - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//   - mem_ready=0: stay in FETCH.
//   - mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
//  DECODE
//   - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target goes to ALUOut).
//   - Next state by opcode:
//     - 000000 with func=001000: JR.
//     - 000000 with other legal func (add, sub, and, or, slt): R_EXEC.
//     - 100011 or 101011: MEM_ADR.
//     - 000100 or 000101: BRANCH.
//     - 001000: I_EXEC.
//     - 000010: JUMP.
//     - 000011: JAL.
//     - anything else: ERROR with err_code=01.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
//  R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, retired=1. Next FETCH.
//  I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next I_WB.
//  I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, retired=1. Next FETCH.
//  MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD if lw, MEM_WR if sw.
//  MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
//  MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, retired=1. Next FETCH.
//  MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready. retired=1 in the mem_ready cycle. Next FETCH.
//  BRANCH
//   - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, retired=1.
//   - pc_write = zero XOR (opcode==000101), so beq is taken on zero=1 and bne on zero=0.
//   - Next FETCH.
//  JUMP: pc_source=10, pc_write=1, retired=1. Next FETCH.
//  JAL: pc_source=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, retired=1. Next FETCH. PC already holds PC+4.
//  JR: alu_src_a=1, pc_source=11, pc_write=1, retired=1. Next FETCH.
//  Wait states (FETCH, MEM_RD, MEM_WR)
//   - wait_cnt clears on entry and increments each cycle mem_ready=0.
//   - wait_cnt==WAIT_LIMIT-1 with mem_ready=0 (WAIT_LIMIT>0): next ERROR with err_code=10.
//   - mem_ready in the limit cycle wins over the timeout.
//   - mem_ready outside wait states is ignored.
//  ERROR: halted=1, all strobes 0, err_code held. Exits only through reset.
//  Zero-wait cycle counts: R/addi 4, lw 5, sw 4, beq/bne/j/jal/jr 3.
// TESTING
//  1. mem_ready=1 always, add $3,$1,$2 (op 000000, func 100000)
//     -> states FETCH, DECODE, R_EXEC, R_WB
//     -> reg_write=1 and reg_dst=01 only in cycle 4; retired pulses once.
//  2. lw with mem_ready low for 2 cycles in MEM_RD
//     -> mem_read=1, i_or_d=1 held for 3 cycles
//     -> MEM_WB follows; 7 cycles total; mem_to_reg=01.
//  3. beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH.
//     beq with zero=0 -> pc_write=0.
//     bne with zero=0 -> pc_write=1.
//  4. opcode 111111 -> ERROR after DECODE; halted=1, err_code=01; no further mem_read until reset.
//  5. WAIT_LIMIT=4, mem_ready=0 in FETCH -> ERROR after 4 cycles, err_code=10.
//     Repeat with mem_ready=1 in cycle 4 -> DECODE.
//  6. reset=0 mid-MEM_WR wait -> mem_write drops immediately.
//     After release, the first cycle is FETCH with mem_read=1.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS sequencer with memory-ready stalls, wait timeout and trap state
module mc_control #(
  parameter int RA_REG = 31,
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retired,
  output logic       halted,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, ERROR
  } state_t;

  localparam int CW = WAIT_LIMIT > 1 ? $clog2(WAIT_LIMIT) : 1;

  // reg_dst=10 selects the link register inside the regfile mux; it must be addressable
  if (RA_REG < 0 || RA_REG > 31) begin : g_ra_check
    $error("mc_control: RA_REG must be a 5-bit register index");
  end

  state_t state, state_next;
  logic [1:0] err, err_next;
  logic [CW-1:0] wait_cnt;
  logic in_wait, timeout, r_legal;

  assign in_wait = state inside {FETCH, MEM_RD, MEM_WR};
  assign timeout = (WAIT_LIMIT > 0) && in_wait && !mem_ready && (wait_cnt == CW'(WAIT_LIMIT - 1));
  assign r_legal = func inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  // State, wait counter and sticky error code; the counter restarts whenever a wait state is entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      err <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      err <= err_next;
      wait_cnt <= (in_wait && state_next == state) ? wait_cnt + 1'b1 : '0;
    end
  end

  // Next state and Moore outputs; every strobe is forced low while reset is held
  always_comb begin
    state_next = state;
    err_next = err;
    pc_write = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    reg_dst = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_source = 2'b00;
    retired = 1'b0;
    halted = 1'b0;
    err_code = 2'b00;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        pc_write = mem_ready;
        ir_write = mem_ready;
        state_next = mem_ready ? DECODE : timeout ? ERROR : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000: state_next = func == 6'b001000 ? JR : r_legal ? R_EXEC : ERROR;
          6'b100011, 6'b101011: state_next = MEM_ADR;
          6'b000100, 6'b000101: state_next = BRANCH;
          6'b001000: state_next = I_EXEC;
          6'b000010: state_next = JUMP;
          6'b000011: state_next = JAL;
          default: state_next = ERROR;
        endcase
        err_next = state_next == ERROR ? 2'b01 : err;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 2'b01;
        retired = 1'b1;
        state_next = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        retired = 1'b1;
        state_next = FETCH;
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_next = opcode == 6'b100011 ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
        state_next = mem_ready ? MEM_WB : timeout ? ERROR : MEM_RD;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 2'b01;
        retired = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
        retired = mem_ready;
        state_next = mem_ready ? FETCH : timeout ? ERROR : MEM_WR;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_source = 2'b01;
        retired = 1'b1;
        pc_write = zero ^ (opcode == 6'b000101);
        state_next = FETCH;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write = 1'b1;
        retired = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        pc_source = 2'b10;
        pc_write = 1'b1;
        reg_write = 1'b1;
        reg_dst = 2'b10;
        mem_to_reg = 2'b10;
        retired = 1'b1;
        state_next = FETCH;
      end
      JR: begin
        alu_src_a = 1'b1;
        pc_source = 2'b11;
        pc_write = 1'b1;
        retired = 1'b1;
        state_next = FETCH;
      end
      default: begin
        halted = 1'b1;
        err_code = err;
        state_next = ERROR;
      end
    endcase
    if (timeout && !mem_ready) err_next = 2'b10;
    if (!reset) begin
      {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg} = '0;
      {alu_src_a, alu_src_b, alu_op, pc_source, retired, halted, err_code} = '0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed and randomized instruction streams checked against a per-instruction step model
module tb_mc_control;
  localparam int WL = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, err_code;
  logic alu_src_a, retired, halted;
  logic [20:0] obs;

  int total = 0;
  int bad = 0;
  int rdy_pct = 100;
  bit rq[$];

  mc_control #(.RA_REG(31), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retired(retired), .halted(halted), .err_code(err_code)
  );

  always #5 clock = ~clock;

  assign obs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_source, retired, halted, err_code};

  function automatic logic [20:0] ov(input int pcw, iord, mr, mw, irw, rw, rd, mtr, asa, asb, aop, ps, ret, hlt, ec);
    return {pcw[0], iord[0], mr[0], mw[0], irw[0], rw[0], rd[1:0], mtr[1:0],
            asa[0], asb[1:0], aop[1:0], ps[1:0], ret[0], hlt[0], ec[1:0]};
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000 && fn == 6'b001000) return 7;
    if (op == 6'b000000) return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                 fn == 6'b100101 || fn == 6'b101010) ? 0 : 8;
    if (op == 6'b100011) return 1;
    if (op == 6'b101011) return 2;
    if (op == 6'b000100 || op == 6'b000101) return 3;
    if (op == 6'b001000) return 4;
    if (op == 6'b000010) return 5;
    if (op == 6'b000011) return 6;
    return 8;
  endfunction

  task automatic check(input logic [20:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [20:0] exp, input string tag);
    @(negedge clock);
    check(exp, tag);
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    mem_ready = 1'($urandom_range(0, 1));
    zero = 1'($urandom_range(0, 1));
  endtask

  function automatic bit pick_ready();
    if (rq.size() > 0) return rq.pop_front();
    return $urandom_range(0, 99) < rdy_pct;
  endfunction

  // A memory access lasts until the first ready cycle, or traps once WL cycles have gone unanswered
  task automatic wait_phase(input int kind, output bit ok);
    bit r;
    ok = 1'b0;
    for (int k = 0; k < WL; k++) begin
      r = pick_ready();
      mem_ready = r;
      zero = 1'($urandom_range(0, 1));
      if (kind == 0) step(ov(r, 0, 1, 0, r, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "fetch");
      else if (kind == 1) step(ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mem_rd");
      else step(ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, r, 0, 0), "mem_wr");
      if (r) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel, output logic [1:0] ec);
    bit ok;
    bit z;
    int cls;
    ec = 2'b00;
    opcode = op;
    func = fn;
    wait_phase(0, ok);
    if (!ok) begin
      ec = 2'b10;
      return;
    end
    noise();
    step(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0), "decode");
    cls = classify(op, fn);
    noise();
    case (cls)
      0: begin
        step(ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0), "r_exec");
        noise();
        step(ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0), "r_wb");
      end
      1, 2: begin
        step(ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), "mem_adr");
        wait_phase(cls, ok);
        if (!ok) ec = 2'b10;
        else if (cls == 1) begin
          noise();
          step(ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0), "mem_wb");
        end
      end
      3: begin
        z = zsel < 0 ? 1'($urandom_range(0, 1)) : 1'(zsel);
        zero = z;
        step(ov((op == 6'b000100) ? z : !z, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0), "branch");
      end
      4: begin
        step(ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), "i_exec");
        noise();
        step(ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "i_wb");
      end
      5: step(ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0), "jump");
      6: step(ov(1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 2, 1, 0, 0), "jal");
      7: step(ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0), "jr");
      default: ec = 2'b01;
    endcase
  endtask

  task automatic halt_steps(input logic [1:0] ec, input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      opcode = 6'($urandom);
      step(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ec), "halted");
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check('0, "reset_out");
    @(posedge clock);
    #1;
    check('0, "reset_hold");
    reset = 1'b1;
  endtask

  task automatic run_checked(input logic [5:0] op, input logic [5:0] fn, input int zsel, input logic [1:0] want);
    logic [1:0] ec;
    run_instr(op, fn, zsel, ec);
    total++;
    assert (ec === want) else begin
      bad++;
      $error("FAIL outcome op=%b observed=%0d expected=%0d", op, ec, want);
    end
    if (ec != 2'b00) begin
      halt_steps(ec, 3);
      do_reset();
    end
  endtask

  initial begin
    logic [11:0] ins[12];
    logic [1:0] ec;
    int sel;
    ins = '{12'b000000_100000, 12'b000000_100010, 12'b000000_100100, 12'b000000_100101,
            12'b000000_101010, 12'b000000_001000, 12'b100011_000000, 12'b101011_000000,
            12'b000100_000000, 12'b000101_000000, 12'b001000_000000, 12'b000010_000000};
    #1;
    check('0, "reset_state");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    run_checked(6'b000000, 6'b100000, -1, 2'b00);
    rq = '{1, 0, 0, 1};
    run_checked(6'b100011, 6'b000000, -1, 2'b00);
    run_checked(6'b000100, 6'b000000, 1, 2'b00);
    run_checked(6'b000100, 6'b000000, 0, 2'b00);
    run_checked(6'b000101, 6'b000000, 0, 2'b00);
    run_checked(6'b000101, 6'b000000, 1, 2'b00);
    run_checked(6'b000010, 6'b000000, -1, 2'b00);
    run_checked(6'b000011, 6'b000000, -1, 2'b00);
    run_checked(6'b000000, 6'b001000, -1, 2'b00);
    run_checked(6'b001000, 6'b000000, -1, 2'b00);
    run_checked(6'b101011, 6'b000000, -1, 2'b00);
    run_checked(6'b111111, 6'b000000, -1, 2'b01);
    run_checked(6'b000000, 6'b000001, -1, 2'b01);
    rq = '{0, 0, 0, 0};
    run_checked(6'b000000, 6'b100000, -1, 2'b10);
    rq = '{0, 0, 0, 1};
    run_checked(6'b000000, 6'b100000, -1, 2'b00);
    rq = '{1, 0, 0, 0, 0};
    run_checked(6'b101011, 6'b000000, -1, 2'b10);
    opcode = 6'b101011;
    rq = '{1};
    wait_phase(0, ec[0]);
    noise();
    step(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0), "decode_sw");
    noise();
    step(ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), "mem_adr_sw");
    mem_ready = 1'b0;
    step(ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mem_wr_wait");
    reset = 1'b0;
    #1;
    total++;
    assert (mem_write === 1'b0) else begin
      bad++;
      $error("FAIL abort_write observed=%b expected=0", mem_write);
    end
    do_reset();
    rq = '{1};
    run_checked(6'b000000, 6'b100010, -1, 2'b00);
    rdy_pct = 70;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 12);
      if (sel == 12) run_checked(6'b110000 | 6'($urandom_range(0, 15)), 6'($urandom), -1, 2'b01);
      else begin
        run_instr(ins[sel][11:6], ins[sel][5:0], -1, ec);
        if (ec != 2'b00) begin
          halt_steps(ec, 2);
          do_reset();
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
